// File: rtl/spike_raster_tx.sv
// Serialises one 128-neuron spike raster per simulation step onto the inter-FPGA spikeout line.
// Frame: preamble 1110, 8-bit seq (MSB first), population[0..127], even parity, then an idle gap.
module spike_raster_tx #(
    parameter int DIV      = 4,
    parameter int GAP_BITS = 2
) (
    input  logic         clk,
    input  logic         reset_global,
    input  logic         sim_clk,
    input  logic [127:0] population,
    input  logic         enable,
    output logic         tx_line,
    output logic         tx_busy,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  overrun_cnt
);

    generate
        if (DIV < 2 || DIV > 255) begin : g_bad_div
            $error("spike_raster_tx: DIV must be within 2..255");
        end
        if (GAP_BITS < 0 || GAP_BITS > 256) begin : g_bad_gap
            $error("spike_raster_tx: GAP_BITS must be within 0..256");
        end
    endgenerate

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);
    localparam int         SR_W     = 136;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SEQ  = 3'd2,
        DATA = 3'd3,
        PAR  = 3'd4,
        GAP  = 3'd5
    } state_t;

    state_t state, state_n;

    logic            sync_1, sync_2, sync_hist, req;
    logic [7:0]      div_cnt, div_n;
    logic [7:0]      bit_cnt, bit_n;
    logic [SR_W-1:0] shreg, shreg_n;
    logic            par_bit, par_n;
    logic            line_n;
    logic [7:0]      seq, seq_n;
    logic [31:0]     frames_n;
    logic [15:0]     ovr_n;
    logic [127:0]    pop_rev;
    logic            bit_end;

    // sim_clk is asynchronous: two sync flops, a history flop, and a registered edge detect.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_hist <= 1'b0;
            req       <= 1'b0;
        end else begin
            sync_1    <= sim_clk;
            sync_2    <= sync_1;
            sync_hist <= sync_2;
            req       <= sync_2 & ~sync_hist;
        end
    end

    // Shift register is MSB-out, so population is loaded bit-reversed to send bit 0 first.
    always_comb begin
        pop_rev = '0;
        for (int i = 0; i < 128; i++) begin
            pop_rev[127 - i] = population[i];
        end
    end

    assign bit_end = (div_cnt == DIV_LAST);
    assign tx_busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        par_n    = par_bit;
        line_n   = tx_line;
        seq_n    = seq;
        frames_n = frame_cnt;
        ovr_n    = overrun_cnt;

        if (req && enable && state != IDLE && overrun_cnt != 16'hFFFF) begin
            ovr_n = overrun_cnt + 16'd1;
        end

        if (state != IDLE) begin
            div_n = bit_end ? 8'd0 : div_cnt + 8'd1;
        end

        case (state)
            IDLE: begin
                line_n = 1'b0;
                if (req && enable) begin
                    state_n = PRE;
                    div_n   = 8'd0;
                    bit_n   = 8'd0;
                    shreg_n = {seq, pop_rev};
                    par_n   = (^seq) ^ (^population);
                    line_n  = 1'b1;
                end
            end
            PRE: begin
                if (bit_end) begin
                    if (bit_cnt == 8'd3) begin
                        state_n = SEQ;
                        bit_n   = 8'd0;
                        line_n  = shreg[SR_W-1];
                    end else begin
                        bit_n  = bit_cnt + 8'd1;
                        // preamble bit 3 is the only zero
                        line_n = (bit_cnt != 8'd2);
                    end
                end
            end
            SEQ: begin
                if (bit_end) begin
                    shreg_n = {shreg[SR_W-2:0], 1'b0};
                    line_n  = shreg[SR_W-2];
                    if (bit_cnt == 8'd7) begin
                        state_n = DATA;
                        bit_n   = 8'd0;
                    end else begin
                        bit_n = bit_cnt + 8'd1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = {shreg[SR_W-2:0], 1'b0};
                    if (bit_cnt == 8'd127) begin
                        state_n = PAR;
                        bit_n   = 8'd0;
                        line_n  = par_bit;
                    end else begin
                        bit_n  = bit_cnt + 8'd1;
                        line_n = shreg[SR_W-2];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    seq_n    = seq + 8'd1;
                    frames_n = frame_cnt + 32'd1;
                    bit_n    = 8'd0;
                    line_n   = 1'b0;
                    state_n  = (GAP_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                line_n = 1'b0;
                if (bit_end) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_n = IDLE;
                        bit_n   = 8'd0;
                    end else begin
                        bit_n = bit_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            state       <= IDLE;
            div_cnt     <= 8'd0;
            bit_cnt     <= 8'd0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tx_line     <= 1'b0;
            seq         <= 8'd0;
            frame_cnt   <= 32'd0;
            overrun_cnt <= 16'd0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            par_bit     <= par_n;
            tx_line     <= line_n;
            seq         <= seq_n;
            frame_cnt   <= frames_n;
            overrun_cnt <= ovr_n;
        end
    end

endmodule

// File: tb/tb_spike_raster_tx.sv
// Directed bench for spike_raster_tx: a DIV=4 instance for framing/timing corner cases
// and a DIV=2 instance run in parallel for the 257-frame sequence-number wrap.
`timescale 1ns/1ps
module tb_spike_raster_tx;

    localparam int DIV    = 4;
    localparam int GAPB   = 2;
    localparam int BUSY   = 141 * DIV + GAPB * DIV;
    localparam int DIV_W  = 2;
    localparam int GAPB_W = 1;
    localparam int BUSY_W = 141 * DIV_W + GAPB_W * DIV_W;

    logic         clk;
    logic         reset_global, sim_clk, enable;
    logic [127:0] population;
    logic         tx_line, tx_busy;
    logic [31:0]  frame_cnt;
    logic [15:0]  overrun_cnt;

    logic         rst_w, sim_w, en_w;
    logic [127:0] pop_w;
    logic         line_w, busy_w;
    logic [31:0]  frames_w;
    logic [15:0]  ovr_w;

    int total, bad;

    spike_raster_tx #(.DIV(DIV), .GAP_BITS(GAPB)) u_dut (
        .clk(clk), .reset_global(reset_global), .sim_clk(sim_clk),
        .population(population), .enable(enable), .tx_line(tx_line),
        .tx_busy(tx_busy), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    spike_raster_tx #(.DIV(DIV_W), .GAP_BITS(GAPB_W)) u_wrap (
        .clk(clk), .reset_global(rst_w), .sim_clk(sim_w),
        .population(pop_w), .enable(en_w), .tx_line(line_w),
        .tx_busy(busy_w), .frame_cnt(frames_w), .overrun_cnt(ovr_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pop;
        logic         en;
        logic [7:0]   seq;
        logic [31:0]  frames;
        logic [15:0]  ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame in transmission order: bit 140 goes out first.
    function automatic logic [140:0] mk_frame(input logic [7:0] s, input logic [127:0] p);
        logic [140:0] f;
        f[140:137] = 4'b1110;
        f[136:129] = s;
        for (int i = 0; i < 128; i++) f[128 - i] = p[i];
        f[0] = (^s) ^ (^p);
        return f;
    endfunction

    task automatic start_frame(input logic [127:0] p, input string nm);
        int n;
        population = p;
        sim_clk    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (tx_line !== 1'b1 && n < 20);
        chk({nm, " latency"}, 64'(n), 64'd4);
        chk({nm, " busy at start"}, 64'(tx_busy), 64'd1);
    endtask

    // Starts at the first-bit cycle (k=0); ends on the first cycle after the gap.
    task automatic frame_body(input logic [140:0] exp, input int rise_at, input int drop_at,
                              input int en_off_at, input string nm);
        int  errs;
        logic e;
        errs = 0;
        for (int k = 0; k < BUSY; k++) begin
            e = (k < 141 * DIV) ? exp[140 - k / DIV] : 1'b0;
            if (tx_line !== e || tx_busy !== 1'b1) errs++;
            if (k == drop_at) sim_clk = 1'b0;
            if (k == rise_at) sim_clk = 1'b1;
            if (rise_at >= 0 && k == rise_at + 12) sim_clk = 1'b0;
            if (k == en_off_at) enable = 1'b0;
            tick();
        end
        chk({nm, " frame bit errors"}, 64'(errs), 64'd0);
        chk({nm, " busy after gap"}, 64'(tx_busy), 64'd0);
        chk({nm, " line after gap"}, 64'(tx_line), 64'd0);
    endtask

    task automatic main_tests();
        logic [127:0] pa, pb, pc, pd, pe;
        int busy_seen;
        pa = 128'hF0F0_0000_1234_5678_0000_0000_0000_0001;
        pb = 128'h0000_0000_0000_0000_0000_0000_0000_0003;
        pc = 128'h5555_5555_AAAA_AAAA_5555_5555_AAAA_AAAA;
        pd = 128'h0000_0001_0000_0000_0000_0000_8000_0000;
        pe = 128'h0004_0000_0000_0000_0000_0000_0000_0000;
        pe[50] = 1'b1;

        repeat (3) tick();
        chk("reset tx_line", 64'(tx_line), 64'd0);
        chk("reset tx_busy", 64'(tx_busy), 64'd0);
        chk("reset frame_cnt", 64'(frame_cnt), 64'd0);
        chk("reset overrun_cnt", 64'(overrun_cnt), 64'd0);
        #2 reset_global = 1'b0;
        repeat (3) tick();

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].en) begin
                enable = 1'b1;
                start_frame(vecs[v].pop, $sformatf("vec%0d", v));
                frame_body(mk_frame(vecs[v].seq, vecs[v].pop), -1, 10, -1, $sformatf("vec%0d", v));
            end else begin
                enable     = 1'b0;
                population = vecs[v].pop;
                sim_clk    = 1'b1;
                busy_seen  = 0;
                repeat (10) begin tick(); if (tx_busy) busy_seen++; end
                sim_clk = 1'b0;
                repeat (10) begin tick(); if (tx_busy) busy_seen++; end
                chk($sformatf("vec%0d no frame", v), 64'(busy_seen), 64'd0);
                enable = 1'b1;
            end
            chk($sformatf("vec%0d frame_cnt", v), 64'(frame_cnt), 64'(vecs[v].frames));
            chk($sformatf("vec%0d overrun_cnt", v), 64'(overrun_cnt), 64'(vecs[v].ovr));
        end

        // second request 100 cycles after the first
        start_frame(pa, "ovr100");
        frame_body(mk_frame(8'd4, pa), 96, 10, -1, "ovr100");
        chk("ovr100 frame_cnt", 64'(frame_cnt), 64'd5);
        chk("ovr100 overrun_cnt", 64'(overrun_cnt), 64'd1);

        // request lands on the last gap cycle: overrun, not accepted
        start_frame(pb, "gapend");
        frame_body(mk_frame(8'd5, pb), BUSY - 4, 10, -1, "gapend");
        sim_clk   = 1'b0;
        busy_seen = 0;
        repeat (8) begin tick(); if (tx_busy) busy_seen++; end
        chk("gapend no restart", 64'(busy_seen), 64'd0);
        chk("gapend overrun_cnt", 64'(overrun_cnt), 64'd2);
        chk("gapend frame_cnt", 64'(frame_cnt), 64'd6);

        // request lands on the first IDLE cycle: accepted back to back
        start_frame(pc, "b2b");
        frame_body(mk_frame(8'd6, pc), BUSY - 3, 10, -1, "b2b first");
        tick();
        frame_body(mk_frame(8'd7, pc), -1, 10, -1, "b2b second");
        chk("b2b frame_cnt", 64'(frame_cnt), 64'd8);
        chk("b2b overrun_cnt", 64'(overrun_cnt), 64'd2);

        // enable drops mid-frame; frame completes, later requests ignored
        start_frame(pd, "endrop");
        frame_body(mk_frame(8'd8, pd), 300, 10, 200, "endrop");
        chk("endrop frame_cnt", 64'(frame_cnt), 64'd9);
        busy_seen = 0;
        repeat (5) begin
            sim_clk = 1'b1;
            repeat (8) begin tick(); if (tx_busy) busy_seen++; end
            sim_clk = 1'b0;
            repeat (8) begin tick(); if (tx_busy) busy_seen++; end
        end
        chk("disabled no frames", 64'(busy_seen), 64'd0);
        chk("disabled frame_cnt", 64'(frame_cnt), 64'd9);
        chk("disabled overrun_cnt", 64'(overrun_cnt), 64'd2);
        enable = 1'b1;

        // reset during DATA bit 50 (frame bit 62)
        start_frame(pe, "midrst");
        repeat (62 * DIV + 1) tick();
        chk("midrst data bit 50", 64'(tx_line), 64'(pe[50]));
        #2 reset_global = 1'b1;
        #1;
        chk("midrst tx_line", 64'(tx_line), 64'd0);
        chk("midrst tx_busy", 64'(tx_busy), 64'd0);
        chk("midrst frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst overrun_cnt", 64'(overrun_cnt), 64'd0);
        sim_clk = 1'b0;
        tick();
        tick();
        #2 reset_global = 1'b0;
        repeat (4) tick();
        start_frame(pe, "postrst");
        frame_body(mk_frame(8'd0, pe), -1, 10, -1, "postrst");
        chk("postrst frame_cnt", 64'(frame_cnt), 64'd1);
    endtask

    task automatic wrap_tests();
        int   errs, tmo, n;
        logic [7:0] seqf;
        logic par3, e;
        logic [140:0] exp;
        errs = 0;
        tmo  = 0;
        seqf = 8'hFF;
        par3 = 1'b1;
        repeat (2) tick();
        #2 rst_w = 1'b0;
        repeat (3) tick();
        for (int f = 0; f < 257; f++) begin
            sim_w = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (line_w !== 1'b1 && n < 20);
            if (n >= 20) tmo++;
            exp = mk_frame(8'(f), pop_w);
            for (int k = 0; k < BUSY_W; k++) begin
                e = (k < 141 * DIV_W) ? exp[140 - k / DIV_W] : 1'b0;
                if (line_w !== e || busy_w !== 1'b1) errs++;
                if (k == 5) sim_w = 1'b0;
                if (f == 256 && k >= 4 * DIV_W && k < 12 * DIV_W && (k % DIV_W) == 0)
                    seqf = {seqf[6:0], line_w};
                if (f == 3 && k == 140 * DIV_W) par3 = line_w;
                tick();
            end
            if (busy_w !== 1'b0) errs++;
        end
        chk("wrap timeouts", 64'(tmo), 64'd0);
        chk("wrap frame errors", 64'(errs), 64'd0);
        chk("wrap frame_cnt", 64'(frames_w), 64'd257);
        chk("wrap seq of frame 257", 64'(seqf), 64'h00);
        chk("wrap parity seq 3 all ones", 64'(par3), 64'd0);
        chk("wrap overrun_cnt", 64'(ovr_w), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{128'h1, 1'b1, 8'd0, 32'd1, 16'd0};
        vecs[1] = '{{128{1'b1}}, 1'b1, 8'd1, 32'd2, 16'd0};
        vecs[2] = '{128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, 1'b0, 8'd0, 32'd2, 16'd0};
        vecs[3] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 8'd2, 32'd3, 16'd0};
        vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 8'd3, 32'd4, 16'd0};
        reset_global = 1'b1;
        sim_clk      = 1'b0;
        enable       = 1'b1;
        population   = '0;
        rst_w        = 1'b1;
        sim_w        = 1'b0;
        en_w         = 1'b1;
        pop_w        = {128{1'b1}};
        fork
            main_tests();
            wrap_tests();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
